sdf_bitrev_reorder: RTL and testbench

//  Output-side reader for the radix-2 SDF FFT pipeline. The last bf_stage emits each

---
 rtl/fft_pkg.sv | 25 ++
 rtl/sdf_pingpong_ram.sv | 41 ++++
 rtl/sdf_bitrev_reorder.sv | 129 ++++++++++++
 tb/tb_sdf_bitrev_reorder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT pipeline types and the bit-reversal helper used by the SDF stages.
package fft_pkg;

  localparam int unsigned FPT_W = 32;
  localparam int unsigned IDX_W = 16;

  typedef logic [FPT_W-1:0] fpt;

  typedef struct packed {
    fpt re;
    fpt im;
  } cpx;

  // Reverse the low n bits of idx; bits at or above n come back as zero.
  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] idx,
                                               input int unsigned n);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < IDX_W; i++) begin
      if (i < n) r[4'(i)] = idx[4'(n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_pingpong_ram.sv
// Two-bank frame buffer: synchronous write port, registered read port that
// returns zero on cycles with no read issued.
module sdf_pingpong_ram #(
  parameter int unsigned AW = 3,
  parameter int unsigned WW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [WW-1:0] wr_data,
  input  logic          rd_en,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [WW-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 * (1 << AW);

  logic [WW-1:0] mem_q [DEPTH];
  logic [WW-1:0] rd_data_q;
  logic [WW-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wr_bank, wr_addr}] <= wr_data;
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_en) rd_data_d = mem_q[{rd_bank, rd_addr}];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sdf_bitrev_reorder.sv
// Captures bit-reversed SDF FFT output frames into a ping-pong buffer and
// replays each committed frame in natural bin order.
module sdf_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_ip,
  input  logic [DW-1:0] ip_re,
  input  logic [DW-1:0] ip_im,
  output logic          start_op,
  output logic          op_valid,
  output logic [DW-1:0] op_re,
  output logic [DW-1:0] op_im
);

  localparam logic [N-1:0] CNT_MAX = '1;

  typedef enum logic { W_IDLE, W_FILL  } w_state_e;
  typedef enum logic { R_IDLE, R_DRAIN } r_state_e;

  w_state_e       w_state_q, w_state_d;
  r_state_e       r_state_q, r_state_d;
  logic [N-1:0]   wcnt_q, wcnt_d;
  logic [N-1:0]   rcnt_q, rcnt_d;
  logic           wbank_q, wbank_d;
  logic           rbank_q, rbank_d;
  logic           start_op_q, start_op_d;
  logic           op_valid_q, op_valid_d;

  logic           commit_c;
  logic           wr_en_c;
  logic [N-1:0]   wr_addr_c;
  logic           rd_en_c;
  logic [2*DW-1:0] rd_data;

  // Writer: a start pulse always opens a fresh frame in the current bank.
  always_comb begin
    w_state_d = w_state_q;
    wcnt_d    = wcnt_q;
    wbank_d   = wbank_q;
    commit_c  = 1'b0;
    wr_en_c   = 1'b0;
    wr_addr_c = N'(bitrev(IDX_W'(wcnt_q), N));
    if (start_ip) begin
      w_state_d = W_FILL;
      wcnt_d    = N'(1);
      wr_en_c   = 1'b1;
      wr_addr_c = '0;
    end else if (w_state_q == W_FILL) begin
      wr_en_c = 1'b1;
      if (wcnt_q == CNT_MAX) begin
        commit_c  = 1'b1;
        wbank_d   = ~wbank_q;
        w_state_d = W_IDLE;
        wcnt_d    = '0;
      end else begin
        wcnt_d = wcnt_q + N'(1);
      end
    end
  end

  // Reader: a commit can only land on the last drain cycle or while idle.
  always_comb begin
    r_state_d  = r_state_q;
    rcnt_d     = rcnt_q;
    rbank_d    = rbank_q;
    rd_en_c    = (r_state_q == R_DRAIN);
    start_op_d = rd_en_c && (rcnt_q == '0);
    op_valid_d = rd_en_c;
    if (commit_c) begin
      r_state_d = R_DRAIN;
      rcnt_d    = '0;
      rbank_d   = wbank_q;
    end else if (rd_en_c && (rcnt_q != CNT_MAX)) begin
      rcnt_d = rcnt_q + N'(1);
    end else begin
      r_state_d = R_IDLE;
      rcnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      start_op_q <= 1'b0;
      op_valid_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      start_op_q <= start_op_d;
      op_valid_q <= op_valid_d;
    end
  end

  sdf_pingpong_ram #(
    .AW (N),
    .WW (2 * DW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_c),
    .wr_bank (wbank_q),
    .wr_addr (wr_addr_c),
    .wr_data ({ip_re, ip_im}),
    .rd_en   (rd_en_c),
    .rd_bank (rbank_q),
    .rd_addr (rcnt_q),
    .rd_data (rd_data)
  );

  assign start_op = start_op_q;
  assign op_valid = op_valid_q;
  assign op_re    = rd_data[2*DW-1:DW];
  assign op_im    = rd_data[DW-1:0];

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Scoreboard bench: a frame-level reference model queues expected natural-order
// bins with their arrival cycle; a monitor compares every cycle of output.
module tb_sdf_bitrev_reorder;

  localparam int N     = 3;
  localparam int DEPTH = 1 << N;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_ip;
  logic [31:0] ip_re;
  logic [31:0] ip_im;
  logic        start_op;
  logic        op_valid;
  logic [31:0] op_re;
  logic [31:0] op_im;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    int          cyc;
    bit          first;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] fr_re[$];
  logic [31:0] fr_im[$];
  bit          fr_active = 1'b0;

  sdf_bitrev_reorder #(.N(N), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_ip (start_ip),
    .ip_re    (ip_re),
    .ip_im    (ip_im),
    .start_op (start_op),
    .op_valid (op_valid),
    .op_re    (op_re),
    .op_im    (op_im)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1);
  end

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < N; i++) if ((k >> i) & 1) r = r | (1 << (N - 1 - i));
    return r;
  endfunction

  // Frame model: collect samples after a start; a full frame of DEPTH samples
  // is emitted as bins 0..DEPTH-1 starting two cycles after its last sample.
  function automatic void model_step(input bit s, input logic [31:0] re,
                                     input logic [31:0] im, input int c);
    exp_t e;
    if (s) begin
      fr_re.delete(); fr_im.delete();
      fr_active = 1'b1;
    end
    if (fr_active) begin
      fr_re.push_back(re);
      fr_im.push_back(im);
      if (fr_re.size() == DEPTH) begin
        for (int j = 0; j < DEPTH; j++) begin
          e.re    = fr_re[brev(j)];
          e.im    = fr_im[brev(j)];
          e.cyc   = c + 2 + j;
          e.first = (j == 0);
          sb_q.push_back(e);
        end
        fr_active = 1'b0;
        fr_re.delete(); fr_im.delete();
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit s, input logic [31:0] re);
    @(negedge clk);
    start_ip = s;
    ip_re    = re;
    ip_im    = ~re;
    model_step(s, re, ~re, cyc);
  endtask

  task automatic frame(input logic [31:0] base);
    for (int k = 0; k < DEPTH; k++) drive(k == 0, base + 32'(k));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom);
  endtask

  // Asynchronous reset mid-stream: everything pending is lost.
  task automatic do_reset(input int n);
    @(negedge clk);
    reset    = 1'b0;
    start_ip = 1'b0;
    sb_q.delete(); fr_re.delete(); fr_im.delete();
    fr_active = 1'b0;
    #1;
    check("async_valid", 32'(op_valid), 32'd0);
    check("async_re", op_re, 32'd0);
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: valid bins are popped and compared; idle cycles must be all-zero.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (op_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bin at cyc %0d: got re %h, required no output", cyc, op_re);
        end else begin
          e = sb_q.pop_front();
          check("op_re", op_re, e.re);
          check("op_im", op_im, e.im);
          check("start_op", 32'(start_op), 32'(e.first));
          check("bin_cycle", cyc, e.cyc);
        end
      end else begin
        check("idle_valid", 32'(op_valid), 32'd0);
        check("idle_start", 32'(start_op), 32'd0);
        check("idle_re", op_re, 32'd0);
        check("idle_im", op_im, 32'd0);
        if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
          checks++; errors++;
          $display("FAIL missed_bin at cyc %0d: got no output, required re %h at cyc %0d",
                   cyc, sb_q[0].re, sb_q[0].cyc);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset    = 1'b0;
    start_ip = 1'b0;
    ip_re    = '0;
    ip_im    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    idle(10);
    for (int k = 0; k < DEPTH; k++) drive(k == 0, 32'(k));
    idle(12);

    for (int f = 0; f < 3; f++) frame(32'(100 * f));
    idle(12);

    for (int k = 0; k < 5; k++) drive(k == 0, 32'(1000 + k));
    frame(32'd2000);
    idle(12);

    frame(32'd3000);
    idle(3);
    do_reset(2);
    idle(12);
    frame(32'd4000);
    idle(12);

    frame(32'd5000);
    idle(12);
    frame(32'd6000);
    idle(12);

    for (int f = 0; f < 10; f++) frame($urandom);
    idle(4);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset(2);
      else drive($urandom_range(0, 6) == 0, $urandom);
    end

    idle(20);
    check("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
